move_sequencer: RTL and testbench
=================================

Name: move_sequencer

Overview:
- Upstream input stage for the tic-tac-toe `game` block.
- Takes nine raw, asynchronous cell push-buttons and synchronizes and debounces them on a single system clock.
- Rejects illegal requests: multiple simultaneous presses, an occupied cell, or a press after the game has ended.
- Emits a clean, single-owner strobe on exactly one of the nine cell-clock lines per accepted move; the falling edge of that strobe is the move event consumed by `game`.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required for both press and release; legal range 1..255; counter width 8.
- STROBE_CYCLES, 2: cycles `cell_strobe` stays high per accepted move; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- btn  input  9  raw cell buttons, bit k = cell k+1; asynchronous, active-high.
- occupied  input  9  cell already taken, from `game` (ikp1 | ikp2).
- game_over  input  1  winP1 | winP2 | draw, from `game`.
- cell_strobe  output  9  one-hot move strobes to `game` clk1..clk9.
- busy  output  1  high whenever the FSM is not in IDLE.
- reject  output  1  one-cycle pulse when a request is refused.
- last_cell  output  4  index 0..8 of the last accepted cell; 4'hF if none since reset.
- turn  output  1  0 = player 1 to move, 1 = player 2 (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all outputs clear immediately.
  - cell_strobe=0, busy=0, reject=0, last_cell=4'hF, turn=0.
  - Synchronizers cleared, FSM forced to IDLE, counters cleared.
  - Reset asserted during STROBE drops the strobe at once; `game` is reset on the same net.
- Input synchronization:
  - btn passes through a 2-flop synchronizer; all logic below uses the synchronized value `s`.
  - occupied and game_over are already synchronous and used directly.
- FSM states: IDLE, DEBOUNCE, STROBE, RELEASE.
- IDLE:
  - s==0: stay in IDLE.
  - s one-hot, game_over=0, occupied[idx]=0: capture idx, clear counter, go to DEBOUNCE.
  - s one-hot but game_over=1 or occupied[idx]=1: pulse reject, go to RELEASE.
  - s has more than one bit set: pulse reject, go to RELEASE.
- DEBOUNCE:
  - Each cycle s==onehot(idx), the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, go to STROBE.
  - s==0 (bounce): return to IDLE, no reject.
  - Any other bit set in s: pulse reject, go to RELEASE.
- STROBE entry check: occupied[idx] and game_over are re-checked on the entry cycle.
  - Either one set: pulse reject, go to RELEASE, no strobe.
  - Otherwise: cell_strobe[idx]=1 for exactly STROBE_CYCLES cycles, other bits 0; last_cell=idx on the first strobe cycle; then go to RELEASE with cell_strobe=0.
- RELEASE:
  - Wait for s==0 for DEBOUNCE_CYCLES consecutive cycles, then go to IDLE.
  - Any press during RELEASE restarts the count; no reject, no strobe.
- Latency: btn held from edge 0 → cell_strobe rises after edge 3+DEBOUNCE_CYCLES (edge 7 at default) and falls STROBE_CYCLES edges later.
- Invariants:
  - cell_strobe is always one-hot or zero.
  - Exactly one strobe per press; a held button never auto-repeats.
  - reject is a registered one-cycle pulse and never coincides with a strobe.
  - busy = (state != IDLE).

Optional Feature:
- Macro: MOVE_SEQ_TURN_EN.
- Defined:
  - `turn` toggles on the last cycle of every STROBE; reset to 0.
  - An accepted strobe with game_over=1 is impossible by construction.
- Undefined: `turn` is tied to 0 and no turn flop exists; `game` tracks turn internally.

Test Plan:
- Reset pulse, then clean press of btn[0] held 20 cycles → cell_strobe=9'h001 high on edges 7–8 only, last_cell=0, busy high until 4 cycles after release, reject never asserted.
- btn[4] bouncing 1-0-1-0 every 2 cycles, then steady → exactly one cell_strobe=9'h010 pulse after the stable window; no reject.
- btn[1] and btn[2] asserted in the same cycle → reject pulses once, no strobe, FSM waits in RELEASE until both are released.
- occupied=9'h001, press btn[0] → reject pulse, no strobe; then press btn[5] → cell_strobe=9'h020, last_cell=5.
- game_over=1, press btn[8] → reject, no strobe. With MOVE_SEQ_TURN_EN: five accepted moves give turn sequence 1,0,1,0,1.
- reset dropped mid-STROBE on cell 6 → cell_strobe=0 immediately, last_cell=4'hF, turn=0, state IDLE; held btn[6] is accepted again only after the full sync+debounce latency following reset release.

Source files
------------

// File: rtl/move_sequencer.sv
// Cell push-button front end for the tic-tac-toe game block: synchronize, debounce, validate, strobe.
// Optional macro MOVE_SEQ_TURN_EN adds a registered turn flop toggled at the end of every strobe.
module move_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned STROBE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btn,
  input  logic [8:0] occupied,
  input  logic       game_over,
  output logic [8:0] cell_strobe,
  output logic       busy,
  output logic       reject,
  output logic [3:0] last_cell,
  output logic       turn
);

  localparam int unsigned NCELL  = 9;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SCNT_W = 4;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, STROBE, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [NCELL-1:0]   btn_meta_q, s_q;
  logic [NCELL-1:0]   cell_q, cell_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [NCELL-1:0]   strobe_q, strobe_d;
  logic               reject_q, reject_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               s_onehot, strobe_done;
  logic [IDX_W-1:0]   s_idx;

  // Two-flop synchronizer for the raw buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      s_q        <= '0;
    end else begin
      btn_meta_q <= btn;
      s_q        <= btn_meta_q;
    end
  end

  always_comb begin
    s_idx = '0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (s_q[i]) s_idx = IDX_W'(i);
    end
  end

  assign s_onehot    = (s_q != '0) && ((s_q & (s_q - NCELL'(1))) == '0);
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign strobe_done = (state_q == STROBE) && (strobe_q != '0) &&
                       (scnt_q == SCNT_W'(STROBE_CYCLES));

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cell_d   = cell_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    scnt_d   = scnt_q;
    strobe_d = strobe_q;
    reject_d = 1'b0;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (s_q != '0) begin
          cnt_d = '0;
          if (s_onehot && !game_over && ((occupied & s_q) == '0)) begin
            cell_d  = s_q;
            idx_d   = s_idx;
            state_d = DEBOUNCE;
          end else begin
            reject_d = 1'b1;
            state_d  = RELEASE;
          end
        end
      end
      DEBOUNCE: begin
        if (s_q == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (s_q == cell_q) begin
          if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
            cnt_d   = '0;
            state_d = STROBE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d    = '0;
          reject_d = 1'b1;
          state_d  = RELEASE;
        end
      end
      STROBE: begin
        // First STROBE cycle re-validates the move before the strobe is raised
        if (strobe_q == '0) begin
          if (game_over || ((occupied & cell_q) != '0)) begin
            cnt_d    = '0;
            reject_d = 1'b1;
            state_d  = RELEASE;
          end else begin
            strobe_d = cell_q;
            last_d   = idx_q;
            scnt_d   = SCNT_W'(1);
          end
        end else if (strobe_done) begin
          strobe_d = '0;
          scnt_d   = '0;
          cnt_d    = '0;
          state_d  = RELEASE;
        end else begin
          scnt_d = scnt_q + SCNT_W'(1);
        end
      end
      RELEASE: begin
        if (s_q != '0) begin
          cnt_d = '0;
        end else if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cell_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      scnt_q   <= '0;
      strobe_q <= '0;
      reject_q <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 4'hF;
    end else begin
      state_q  <= state_d;
      cell_q   <= cell_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      scnt_q   <= scnt_d;
      strobe_q <= strobe_d;
      reject_q <= reject_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

`ifdef MOVE_SEQ_TURN_EN
  logic turn_q, turn_d;

  assign turn_d = turn_q ^ strobe_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) turn_q <= 1'b0;
    else        turn_q <= turn_d;
  end

  assign turn = turn_q;
`else
  assign turn = 1'b0;
`endif

  assign cell_strobe = strobe_q;
  assign busy        = busy_q;
  assign reject      = reject_q;
  assign last_cell   = last_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: stimulus table plus hand-built bounce, entry-reject and mid-strobe reset sequences.
module tb_move_sequencer;

  localparam int DEB = 4;
  localparam int STB = 2;
  localparam int LAT = 3 + DEB;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] btn, occupied;
  logic       game_over;
  logic [8:0] cell_strobe;
  logic       busy, reject, turn;
  logic [3:0] last_cell;

  move_sequencer #(.DEBOUNCE_CYCLES(DEB), .STROBE_CYCLES(STB)) dut (
    .clk(clk), .reset(reset), .btn(btn), .occupied(occupied), .game_over(game_over),
    .cell_strobe(cell_strobe), .busy(busy), .reject(reject), .last_cell(last_cell), .turn(turn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] btn;
    logic [8:0] occ;
    logic       go;
    int         hold;
    logic [8:0] strobe;
    int         start;
    int         rej;
    int         rej_rel;
    logic [3:0] last;
    int         busy_fall;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  vec_t exp_q[$];
  logic exp_turn = 1'b0;

  // Monitor state, all times relative to edge 0 = first posedge after arm()
  bit         mon_on = 0;
  int         t0, n_strobe, st_start, st_len, n_rej, rej_rel, busy_fall;
  logic [8:0] st_val, prev_strobe;
  logic       prev_busy;
  bit         inv_bad;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    int rel;
    rel = edge_cnt - t0 - 1;
    if (mon_on && rel >= 0) begin
      if (cell_strobe != 9'd0) begin
        if (prev_strobe == 9'd0) begin
          n_strobe++;
          st_start = rel;
          st_val   = cell_strobe;
        end
        st_len++;
      end
      if (reject) begin
        if (n_rej == 0) rej_rel = rel;
        n_rej++;
      end
      if (prev_busy && !busy) busy_fall = rel;
      if (!$onehot0(cell_strobe) || (reject && cell_strobe != 9'd0)) inv_bad = 1;
      prev_strobe = cell_strobe;
      prev_busy   = busy;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic arm();
    n_strobe = 0; st_start = -1; st_len = 0; st_val = 9'd0;
    n_rej = 0; rej_rel = -1; busy_fall = -1; inv_bad = 0;
    prev_strobe = cell_strobe;
    prev_busy   = busy;
    t0 = edge_cnt;
    mon_on = 1;
  endtask

  // Wait for the sequencer to return to IDLE, then score against the oldest expectation
  task automatic finish_vec(input string tag);
    vec_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || (edge_cnt - t0 - 1) < 3) && n < 300);
    chk({tag, ".timeout"}, (n >= 300) ? 1 : 0, 0);
    repeat (2) @(negedge clk);
    mon_on = 0;
    e = exp_q.pop_front();
`ifdef MOVE_SEQ_TURN_EN
    if (e.strobe != 9'd0) exp_turn = ~exp_turn;
`endif
    chk({tag, ".n_strobe"}, n_strobe, (e.strobe != 9'd0) ? 1 : 0);
    if (e.strobe != 9'd0) begin
      chk({tag, ".strobe_val"}, int'(st_val), int'(e.strobe));
      chk({tag, ".strobe_start"}, st_start, e.start);
      chk({tag, ".strobe_len"}, st_len, STB);
    end
    chk({tag, ".n_reject"}, n_rej, e.rej);
    if (e.rej > 0) chk({tag, ".reject_cycle"}, rej_rel, e.rej_rel);
    chk({tag, ".last_cell"}, int'(last_cell), int'(e.last));
    chk({tag, ".busy_fall"}, busy_fall, e.busy_fall);
    chk({tag, ".turn"}, int'(turn), int'(exp_turn));
    chk({tag, ".invariants"}, int'(inv_bad), 0);
  endtask

  task automatic run(input vec_t v, input string tag);
    @(negedge clk);
    occupied  = v.occ;
    game_over = v.go;
    btn       = v.btn;
    exp_q.push_back(v);
    arm();
    repeat (v.hold) @(negedge clk);
    btn = 9'd0;
    finish_vec(tag);
    occupied  = 9'd0;
    game_over = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t h;

  initial begin
    //            btn     occ     go   hold strobe  start rej rrel last   busy_fall
    tbl[0] = '{9'h001, 9'h000, 1'b0, 20, 9'h001, LAT, 0, 0, 4'd0, 20 + 1 + DEB};
    tbl[1] = '{9'h006, 9'h000, 1'b0, 10, 9'h000, 0,   1, 2, 4'd0, 10 + 1 + DEB};
    tbl[2] = '{9'h001, 9'h001, 1'b0,  8, 9'h000, 0,   1, 2, 4'd0,  8 + 1 + DEB};
    tbl[3] = '{9'h020, 9'h001, 1'b0, 12, 9'h020, LAT, 0, 0, 4'd5, 12 + 1 + DEB};
    tbl[4] = '{9'h100, 9'h000, 1'b1,  6, 9'h000, 0,   1, 2, 4'd5,  6 + 1 + DEB};
    tbl[5] = '{9'h008, 9'h000, 1'b0,  3, 9'h000, 0,   0, 0, 4'd5,  5};
    tbl[6] = '{9'h080, 9'h000, 1'b0, 15, 9'h080, LAT, 0, 0, 4'd7, 15 + 1 + DEB};
    tbl[7] = '{9'h002, 9'h000, 1'b0,  9, 9'h002, LAT, 0, 0, 4'd1,  9 + 1 + DEB};
    tbl[8] = '{9'h004, 9'h000, 1'b0,  9, 9'h004, LAT, 0, 0, 4'd2,  9 + 1 + DEB};
    tbl[9] = '{9'h100, 9'h000, 1'b0,  9, 9'h100, LAT, 0, 0, 4'd8,  9 + 1 + DEB};

    reset = 1'b0; btn = 9'd0; occupied = 9'd0; game_over = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.cell_strobe", int'(cell_strobe), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.reject", int'(reject), 0);
    chk("reset.last_cell", int'(last_cell), 15);
    chk("reset.turn", int'(turn), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Bounce 1-0-1-0 every two cycles on cell 4, then steady from edge 8
    @(negedge clk);
    h = '{9'h010, 9'h000, 1'b0, 0, 9'h010, 8 + LAT, 0, 0, 4'd4, 20 + 1 + DEB};
    btn = 9'h010;
    exp_q.push_back(h);
    arm();
    repeat (2) @(negedge clk); btn = 9'h000;
    repeat (2) @(negedge clk); btn = 9'h010;
    repeat (2) @(negedge clk); btn = 9'h000;
    repeat (2) @(negedge clk); btn = 9'h010;
    repeat (12) @(negedge clk); btn = 9'h000;
    finish_vec("bounce");

    // Cell becomes occupied while debouncing: refused on the STROBE entry cycle
    @(negedge clk);
    h = '{9'h008, 9'h000, 1'b0, 0, 9'h000, 0, 1, LAT, 4'd4, 10 + 1 + DEB};
    btn = 9'h008;
    exp_q.push_back(h);
    arm();
    repeat (5) @(negedge clk); occupied = 9'h008;
    repeat (5) @(negedge clk); btn = 9'h000;
    finish_vec("entry_reject");
    occupied = 9'd0;

    // Reset in the middle of a strobe on cell 6, button kept held through reset
    @(negedge clk);
    btn = 9'h040;
    arm();
    repeat (LAT + 1) @(negedge clk);
    chk("midstrobe.pre_strobe", int'(cell_strobe), 'h040);
    mon_on = 0;
    reset = 1'b0;
    #1;
    chk("midstrobe.cell_strobe", int'(cell_strobe), 0);
    chk("midstrobe.last_cell", int'(last_cell), 15);
    chk("midstrobe.turn", int'(turn), 0);
    chk("midstrobe.busy", int'(busy), 0);
    exp_turn = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    h = '{9'h040, 9'h000, 1'b0, 0, 9'h040, LAT, 0, 0, 4'd6, 12 + 1 + DEB};
    exp_q.push_back(h);
    arm();
    repeat (12) @(negedge clk); btn = 9'h000;
    finish_vec("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
